// File: rtl/icache_pkg.sv
// icache_pkg: types and constants shared by the instruction cache and the
// memory controller, plus a word-select helper for 128-bit lines.
package icache_pkg;

    typedef logic [31:0]  ADDR_TP;
    typedef logic [31:0]  WORD_TP;
    typedef logic [127:0] LINE_TP;

    localparam ADDR_TP ZERO_ADDR = 32'h0000_0000;
    localparam WORD_TP ZERO_WORD = 32'h0000_0000;
    localparam logic   TRUE      = 1'b1;
    localparam logic   FALSE     = 1'b0;

    // Select one 32-bit word of a line; word 0 holds bytes 0..3.
    function automatic WORD_TP line_word(input LINE_TP line, input logic [1:0] sel);
        WORD_TP w;
        case (sel)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = ZERO_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// Serves fetches from its line array; a miss issues one 16-byte line fetch to
// memctrl, installs the returned line and then answers the pending fetch from
// the stored line. At most one refill is outstanding.
//
// Ports:
//   clk, rst (async, active-low), rdy (global stall when low), flush
//   if_valid / if_pc            fetch request, held until if_done
//   if_done / if_inst           one-cycle completion pulse and instruction
//   icache_fc_valid / _addr     line-fetch request to memctrl
//   icache_fc_done / _line      refill completion pulse and line data
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         flush,
    input  logic         if_valid,
    input  logic [31:0]  if_pc,
    output logic         if_done,
    output logic [31:0]  if_inst,
    output logic         icache_fc_valid,
    output logic [31:0]  icache_fc_addr,
    input  logic         icache_fc_done,
    input  logic [127:0] icache_fc_line
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 28 - IDX_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_r;
    logic             pend_r;
    // Word address of the missing fetch (byte offset bits are never needed).
    logic [29:0]      pc_r;
    logic [LINE_NUM-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINE_NUM];
    LINE_TP           data_r [LINE_NUM];

    logic [IDX_W-1:0] req_idx_s;
    logic [TAG_W-1:0] req_tag_s;
    logic [IDX_W-1:0] pend_idx_s;
    logic [TAG_W-1:0] pend_tag_s;
    logic             hit_s;
    logic             fill_s;
    WORD_TP           req_word_s;
    WORD_TP           pend_word_s;
    logic             unused_s;

    assign req_idx_s   = if_pc[4 +: IDX_W];
    assign req_tag_s   = if_pc[31 -: TAG_W];
    assign pend_idx_s  = pc_r[2 +: IDX_W];
    assign pend_tag_s  = pc_r[29 -: TAG_W];
    assign hit_s       = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign fill_s      = rdy && (state_r == ST_MISS) && icache_fc_done;
    assign req_word_s  = line_word(data_r[req_idx_s], if_pc[3:2]);
    // Read back from the array so the response always reflects what was installed.
    assign pend_word_s = line_word(data_r[pend_idx_s], pc_r[1:0]);
    // The byte offset within a word is ignored for instruction fetch.
    assign unused_s    = &{1'b0, if_pc[1:0]};

    // Control FSM, valid bits and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            pend_r          <= FALSE;
            pc_r            <= 30'd0;
            valid_r         <= {LINE_NUM{1'b0}};
            if_done         <= FALSE;
            if_inst         <= ZERO_WORD;
            icache_fc_valid <= FALSE;
            icache_fc_addr  <= ZERO_ADDR;
        end else if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    if_done <= FALSE;
                    // While if_done is high the fetch unit still shows the
                    // completed request; sampling it would answer it twice.
                    if (if_valid && !flush && !if_done) begin
                        if (hit_s) begin
                            if_done <= TRUE;
                            if_inst <= req_word_s;
                        end else begin
                            icache_fc_valid <= TRUE;
                            icache_fc_addr  <= {if_pc[31:4], 4'b0000};
                            pc_r            <= if_pc[31:2];
                            pend_r          <= TRUE;
                            state_r         <= ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if_done <= FALSE;
                    if (flush) begin
                        pend_r <= FALSE;
                    end
                    // Dropping valid on the done edge keeps memctrl from reissuing.
                    if (icache_fc_done) begin
                        valid_r[pend_idx_s] <= TRUE;
                        icache_fc_valid     <= FALSE;
                        state_r             <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (pend_r && !flush) begin
                        if_done <= TRUE;
                        if_inst <= pend_word_s;
                    end else begin
                        if_done <= FALSE;
                    end
                    pend_r  <= FALSE;
                    state_r <= ST_IDLE;
                end
                default: begin
                    if_done         <= FALSE;
                    icache_fc_valid <= FALSE;
                    pend_r          <= FALSE;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: written only on refill, intentionally not reset.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[pend_idx_s]  <= pend_tag_s;
            data_r[pend_idx_s] <= icache_fc_line;
        end
    end

endmodule
